// File: rtl/sp_ram_stream_master.sv
// Burst initiator for a single-port RAM with 1-cycle read latency.
// Write bursts pass the input stream straight through; read bursts use a 2-entry FIFO.
module sp_ram_stream_master #(
  parameter int RAM_SIZE   = 32768,
  parameter int ADDR_WIDTH = $clog2(RAM_SIZE),
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = ADDR_WIDTH - 1
) (
  input  logic                    clk,
  input  logic                    rst_i,
  input  logic                    cmd_valid_i,
  output logic                    cmd_ready_o,
  input  logic                    cmd_write_i,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr_i,
  input  logic [LEN_WIDTH-1:0]    cmd_len_i,
  input  logic                    wr_valid_i,
  output logic                    wr_ready_o,
  input  logic [DATA_WIDTH-1:0]   wr_data_i,
  input  logic [DATA_WIDTH/8-1:0] wr_be_i,
  output logic                    rd_valid_o,
  input  logic                    rd_ready_i,
  output logic [DATA_WIDTH-1:0]   rd_data_o,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    ram_en_o,
  output logic [ADDR_WIDTH-1:0]   ram_addr_o,
  output logic [DATA_WIDTH-1:0]   ram_wdata_o,
  output logic                    ram_we_o,
  output logic [DATA_WIDTH/8-1:0] ram_be_o,
  input  logic [DATA_WIDTH-1:0]   ram_rdata_i
);

  localparam int BE_WIDTH = DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WR    = 2'd1,
    ST_RD    = 2'd2,
    ST_FLUSH = 2'd3
  } state_t;

  state_t                state_r;
  logic [ADDR_WIDTH-1:0] addr_r;
  logic [LEN_WIDTH-1:0]  remaining_r;
  logic                  done_r;
  logic                  inflight_r;
  logic [DATA_WIDTH-1:0] fifo_mem_r [2];
  logic                  wr_ptr_r;
  logic                  rd_ptr_r;
  logic [1:0]            fifo_cnt_r;

  logic                  cmd_hs_s;
  logic                  wr_hs_s;
  logic                  pop_s;
  logic                  push_s;
  logic                  issue_s;
  logic                  last_pop_s;
  logic [2:0]            occupancy_s;
  logic [ADDR_WIDTH-1:0] addr_next_s;
  logic [ADDR_WIDTH-1:0] cmd_addr_aligned_s;

  assign cmd_ready_o = (state_r == ST_IDLE);
  assign busy_o      = (state_r != ST_IDLE);
  assign done_o      = done_r;
  assign rd_valid_o  = (fifo_cnt_r != 2'd0);
  assign rd_data_o   = fifo_mem_r[rd_ptr_r];
  assign ram_addr_o  = addr_r;

  assign cmd_hs_s           = cmd_valid_i & cmd_ready_o;
  assign wr_hs_s            = (state_r == ST_WR) & wr_valid_i;
  assign pop_s              = rd_valid_o & rd_ready_i;
  assign push_s             = inflight_r;
  assign cmd_addr_aligned_s = cmd_addr_i & ~ADDR_WIDTH'(BE_WIDTH - 1);
  // Address arithmetic is naturally modulo RAM_SIZE because RAM_SIZE is a power of two.
  assign addr_next_s        = addr_r + ADDR_WIDTH'(BE_WIDTH);

  // Words committed to the FIFO after this cycle: buffered + returning - leaving.
  assign occupancy_s = {1'b0, fifo_cnt_r} + {2'b00, inflight_r} - {2'b00, pop_s};
  assign issue_s     = (state_r == ST_RD) && (remaining_r != LEN_WIDTH'(0)) &&
                       (occupancy_s < 3'd2);
  assign last_pop_s  = !inflight_r &&
                       ((fifo_cnt_r == 2'd0) || ((fifo_cnt_r == 2'd1) && pop_s));

  // RAM port and write-stream handshake decode
  always_comb begin
    wr_ready_o  = 1'b0;
    ram_en_o    = 1'b0;
    ram_we_o    = 1'b0;
    ram_wdata_o = {DATA_WIDTH{1'b0}};
    ram_be_o    = {BE_WIDTH{1'b0}};
    case (state_r)
      ST_WR: begin
        wr_ready_o  = 1'b1;
        ram_en_o    = wr_valid_i;
        ram_we_o    = wr_valid_i;
        ram_wdata_o = wr_data_i;
        ram_be_o    = wr_be_i;
      end
      ST_RD: begin
        ram_en_o = issue_s;
        if (issue_s) begin
          ram_be_o = {BE_WIDTH{1'b1}};
        end else begin
          ram_be_o = {BE_WIDTH{1'b0}};
        end
      end
      default: begin
        ram_en_o = 1'b0;
      end
    endcase
  end

  // Burst sequencing: address/length bookkeeping and completion pulse
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      state_r     <= ST_IDLE;
      addr_r      <= ADDR_WIDTH'(0);
      remaining_r <= LEN_WIDTH'(0);
      done_r      <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (cmd_hs_s) begin
            addr_r      <= cmd_addr_aligned_s;
            remaining_r <= cmd_len_i;
            if (cmd_len_i == LEN_WIDTH'(0)) begin
              done_r <= 1'b1;
            end else if (cmd_write_i) begin
              state_r <= ST_WR;
            end else begin
              state_r <= ST_RD;
            end
          end
        end
        ST_WR: begin
          if (wr_hs_s) begin
            addr_r      <= addr_next_s;
            remaining_r <= remaining_r - LEN_WIDTH'(1);
            if (remaining_r == LEN_WIDTH'(1)) begin
              state_r <= ST_IDLE;
              done_r  <= 1'b1;
            end
          end
        end
        ST_RD: begin
          if (issue_s) begin
            addr_r      <= addr_next_s;
            remaining_r <= remaining_r - LEN_WIDTH'(1);
            if (remaining_r == LEN_WIDTH'(1)) begin
              state_r <= ST_FLUSH;
            end
          end
        end
        ST_FLUSH: begin
          if (last_pop_s) begin
            state_r <= ST_IDLE;
            done_r  <= 1'b1;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  // Read-return FIFO: captures RAM data the cycle after each issue
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      inflight_r    <= 1'b0;
      wr_ptr_r      <= 1'b0;
      rd_ptr_r      <= 1'b0;
      fifo_cnt_r    <= 2'd0;
      fifo_mem_r[0] <= {DATA_WIDTH{1'b0}};
      fifo_mem_r[1] <= {DATA_WIDTH{1'b0}};
    end else begin
      inflight_r <= issue_s;
      if (push_s) begin
        fifo_mem_r[wr_ptr_r] <= ram_rdata_i;
        wr_ptr_r             <= ~wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= ~rd_ptr_r;
      end
      fifo_cnt_r <= fifo_cnt_r + {1'b0, push_s} - {1'b0, pop_s};
    end
  end

endmodule
